// File: rtl/rhd_spi_slave_bank.sv
// rtl/rhd_spi_slave_bank.sv - RHD-style SPI slave bank emulator; RHD_SLAVE_REGFILE_EN adds the 64x8 register file
`timescale 1ns/1ps
module rhd_spi_slave_bank #(
    parameter int NUM_LANES     = 32,
    parameter int NUM_CHANNELS  = 64,
    parameter int STARTING_SEED = 0,
    parameter int SEED_STRIDE   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCLK,
    input  logic                 CS,
    input  logic                 MOSI,
    output logic [NUM_LANES-1:0] MISO,
    output logic                 frame_done,
    output logic [15:0]          cmd_last,
    output logic [15:0]          sample_count
);

    logic [1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic        sclk_prev_q, cs_prev_q;
    logic        sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q, mosi_bit_q;
    logic        active_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] cmd_sr_q;
    logic [15:0] shift_q [NUM_LANES];
    logic [15:0] resp1_q [NUM_LANES];
    logic [15:0] resp2_q [NUM_LANES];
    logic [15:0] resp_d  [NUM_LANES];
    logic [NUM_LANES-1:0] miso_q;
    logic        frame_done_q;
    logic [15:0] cmd_last_q, sample_count_q, sample_count_d;
    logic        cmd_done;
    int          conv_ch;

    // Synchronisers track the pins through reset so a held-low CS never fakes a frame start.
    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[0], SCLK};
        cs_sync_q   <= {cs_sync_q[0], CS};
        mosi_sync_q <= {mosi_sync_q[0], MOSI};
        sclk_prev_q <= sclk_sync_q[1];
        cs_prev_q   <= cs_sync_q[1];
    end

    assign cmd_done = active_q & cs_rise_q & ~cs_fall_q & (bit_cnt_q == 5'd16);
    assign sample_count_d = ((cmd_sr_q[15:14] == 2'b00) && (cmd_sr_q[13:8] == 6'd0))
                          ? sample_count_q + 16'd1 : sample_count_q;

`ifdef RHD_SLAVE_REGFILE_EN
    logic [7:0] rf_q [64];
    logic [7:0] rf_rdata;
    logic       rf_ro;

    assign rf_ro = (cmd_sr_q[13:8] >= 6'd40) && (cmd_sr_q[13:8] <= 6'd44);

    always_comb begin
        rf_rdata = rf_q[cmd_sr_q[13:8]];
        case (cmd_sr_q[13:8])
            6'd40:   rf_rdata = 8'h49;
            6'd41:   rf_rdata = 8'h4E;
            6'd42:   rf_rdata = 8'h54;
            6'd43:   rf_rdata = 8'h41;
            6'd44:   rf_rdata = 8'h4E;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) rf_q[i] <= 8'h00;
        end else if (cmd_done && cmd_sr_q[15:14] == 2'b10 && !rf_ro) begin
            rf_q[cmd_sr_q[13:8]] <= cmd_sr_q[7:0];
        end
    end
`endif

    // Response each lane will queue if the current command completes.
    always_comb begin
        conv_ch = int'(cmd_sr_q[13:8]);
        for (int l = 0; l < NUM_LANES; l++) begin
            resp_d[l] = 16'h0000;
            case (cmd_sr_q[15:14])
                2'b00: if (conv_ch < NUM_CHANNELS)
                    resp_d[l] = 16'(STARTING_SEED + l * SEED_STRIDE + conv_ch + int'(sample_count_q));
                2'b10: resp_d[l] = {8'hFF, cmd_sr_q[7:0]};
`ifdef RHD_SLAVE_REGFILE_EN
                2'b11: resp_d[l] = {8'h00, rf_rdata};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_rise_q    <= 1'b0;
            sclk_fall_q    <= 1'b0;
            cs_fall_q      <= 1'b0;
            cs_rise_q      <= 1'b0;
            mosi_bit_q     <= 1'b0;
            active_q       <= 1'b0;
            bit_cnt_q      <= 5'd0;
            cmd_sr_q       <= 16'h0000;
            miso_q         <= '0;
            frame_done_q   <= 1'b0;
            cmd_last_q     <= 16'h0000;
            sample_count_q <= 16'h0000;
            for (int l = 0; l < NUM_LANES; l++) begin
                shift_q[l] <= 16'h0000;
                resp1_q[l] <= 16'h0000;
                resp2_q[l] <= 16'h0000;
            end
        end else begin
            sclk_rise_q  <= sclk_sync_q[1] & ~sclk_prev_q;
            sclk_fall_q  <= ~sclk_sync_q[1] & sclk_prev_q;
            cs_fall_q    <= ~cs_sync_q[1] & cs_prev_q;
            cs_rise_q    <= cs_sync_q[1] & ~cs_prev_q;
            mosi_bit_q   <= mosi_sync_q[1];
            frame_done_q <= 1'b0;
            // Frame start wins over any SCLK edge seen in the same cycle.
            if (cs_fall_q) begin
                active_q  <= 1'b1;
                bit_cnt_q <= 5'd0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    shift_q[l] <= resp2_q[l];
                    miso_q[l]  <= resp2_q[l][15];
                end
            end else if (active_q) begin
                if (cs_rise_q) begin
                    active_q <= 1'b0;
                    miso_q   <= '0;
                    if (cmd_done) begin
                        cmd_last_q     <= cmd_sr_q;
                        frame_done_q   <= 1'b1;
                        sample_count_q <= sample_count_d;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            resp2_q[l] <= resp1_q[l];
                            resp1_q[l] <= resp_d[l];
                        end
                    end
                end else if (sclk_rise_q && bit_cnt_q != 5'd16) begin
                    cmd_sr_q  <= {cmd_sr_q[14:0], mosi_bit_q};
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end else if (sclk_fall_q) begin
                    // Zero fill makes MISO fall to 0 once all 16 bits are out.
                    for (int l = 0; l < NUM_LANES; l++) begin
                        shift_q[l] <= {shift_q[l][14:0], 1'b0};
                        miso_q[l]  <= shift_q[l][14];
                    end
                end
            end
        end
    end

    assign MISO         = miso_q;
    assign frame_done   = frame_done_q;
    assign cmd_last     = cmd_last_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_rhd_spi_slave_bank.sv
// tb/tb_rhd_spi_slave_bank.sv - scoreboard bench for rhd_spi_slave_bank against a behavioural slave model
`timescale 1ns/1ps
module tb_rhd_spi_slave_bank;
    localparam int NL     = 32;
    localparam int NC     = 48;
    localparam int SEED   = 0;
    localparam int STRIDE = 64;
    localparam int HALF   = 60;

    logic clk = 1'b0, rst = 1'b1, SCLK = 1'b0, CS = 1'b1, MOSI = 1'b0;
    logic [NL-1:0] MISO;
    logic frame_done;
    logic [15:0] cmd_last, sample_count;

    rhd_spi_slave_bank #(.NUM_LANES(NL), .NUM_CHANNELS(NC), .STARTING_SEED(SEED), .SEED_STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .frame_done(frame_done), .cmd_last(cmd_last), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [15:0]      cmd;
        logic [NL*16-1:0] resp;
        logic [15:0]      sc;
    } sb_t;
    sb_t sb_q[$];

    logic [NL*16-1:0] m_hist[$];
    int               m_sc;
    logic [7:0]       m_rf[64];
    logic [15:0]      m_last;
    logic [7:0]       intan[5] = '{8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E};
    time              cs_rise_t = 0;

    task automatic check(input string name, input logic [NL*16-1:0] act, input logic [NL*16-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input int r);
        if (r >= 40 && r <= 44) return intan[r-40];
        return m_rf[r];
    endfunction

    function automatic logic [NL*16-1:0] m_resp(input logic [15:0] c);
        logic [NL*16-1:0] v;
        logic [15:0] w;
        int ch;
        v  = '0;
        ch = int'(c[13:8]);
        for (int l = 0; l < NL; l++) begin
            w = 16'h0000;
            if (c[15:14] == 2'b00 && ch < NC) w = 16'((SEED + l * STRIDE + ch + m_sc) % 65536);
            else if (c[15:14] == 2'b10) w = {8'hFF, c[7:0]};
`ifdef RHD_SLAVE_REGFILE_EN
            else if (c[15:14] == 2'b11) w = {8'h00, m_read(ch)};
`endif
            v[l*16 +: 16] = w;
        end
        return v;
    endfunction

    task automatic m_reset();
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
        m_sc   = 0;
        m_last = 16'h0000;
        for (int i = 0; i < 64; i++) m_rf[i] = 8'h00;
    endtask

    task automatic m_complete(input logic [15:0] c);
        int r;
        r = int'(c[13:8]);
        void'(m_hist.pop_front());
        m_hist.push_back(m_resp(c));
        if (c[15:14] == 2'b00 && r == 0) m_sc = (m_sc + 1) % 65536;
        if (c[15:14] == 2'b10 && !(r >= 40 && r <= 44)) m_rf[r] = c[7:0];
        m_last = c;
    endtask

    // rst_bit >= 0 pulses rst after that many SCLK pulses minus one (index of the pulse).
    task automatic frame(input logic [15:0] c, input int nbits, input int rst_bit);
        logic [NL*16-1:0] exp;
        sb_t it;
        logic got_rst;
        exp     = m_hist[0];
        got_rst = 1'b0;
        CS   = 1'b0;
        MOSI = c[15];
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b1;
            #HALF;
            SCLK = 1'b0;
            MOSI = (i + 1 < 16) ? c[14-i] : 1'($urandom);
            if (i == rst_bit) begin
                rst = 1'b1;
                #10;
                rst = 1'b0;
                got_rst = 1'b1;
                check("rst_miso", MISO, '0);
                check("rst_cmd_last", cmd_last, 0);
                check("rst_sample_count", sample_count, 0);
                m_reset();
                #(HALF-10);
            end else begin
                #HALF;
            end
        end
        if (nbits >= 16 && !got_rst) begin
            m_complete(c);
            it.cmd  = c;
            it.resp = exp;
            it.sc   = 16'(m_sc);
            sb_q.push_back(it);
        end
        CS = 1'b1;
        cs_rise_t = $time;
        #200;
        if (nbits < 16) check("abort_cmd_last", cmd_last, m_last);
    endtask

    logic [NL*16-1:0] cap;
    int  cap_n = 0;
    logic fd_prev = 1'b0;

    always @(negedge CS) begin
        cap   = '0;
        cap_n = 0;
    end

    always @(posedge SCLK) begin
        if (!CS && cap_n < 16) begin
            for (int l = 0; l < NL; l++) cap[l*16 + 15 - cap_n] = MISO[l];
            cap_n++;
        end
    end

    always @(negedge clk) begin
        sb_t it;
        if (fd_prev) check("frame_done_width", frame_done, 0);
        if (frame_done) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
            end else begin
                it = sb_q.pop_front();
                check("cmd_last", cmd_last, it.cmd);
                check("miso_word", cap, it.resp);
                check("sample_count", sample_count, it.sc);
                check("frame_done_latency", $time - cs_rise_t, 40);
            end
        end
        fd_prev = frame_done;
    end

    initial begin
        logic [15:0] c;
        int t, nb;
        m_reset();
        repeat (5) @(negedge clk);
        check("reset_miso", MISO, '0);
        check("reset_frame_done", frame_done, 0);
        check("reset_cmd_last", cmd_last, 0);
        check("reset_sample_count", sample_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame(16'h0500, 16, -1);
        frame(16'h0000, 16, -1);
        frame(16'h0000, 16, -1);
        frame(16'h0000, 16, -1);
        frame(16'h8A3C, 16, -1);
        frame(16'h6A00, 16, -1);
        frame(16'h6A00, 16, -1);
        frame(16'hCA00, 16, -1);
        frame(16'h6A00, 16, -1);
        frame(16'h6A00, 16, -1);
        for (int r = 40; r <= 44; r++) frame({2'b11, 6'(r), 8'h00}, 16, -1);
        frame(16'hA955, 16, -1);
        frame(16'hE900, 16, -1);
        frame(16'h9477, 16, -1);
        frame(16'hD400, 16, -1);
        frame(16'h6A00, 16, -1);
        frame(16'h6A00, 16, -1);
        frame(16'h0100, 9, -1);
        frame(16'h0700, 16, -1);
        frame(16'h0200, 20, -1);
        frame(16'h6A00, 16, -1);
        frame(16'h6A00, 16, -1);
        frame(16'h0300, 16, 6);
        frame(16'h0000, 16, -1);
        frame(16'h0000, 16, -1);

        for (int k = 0; k < 40; k++) begin
            c = 16'($urandom);
            t = $urandom_range(0, 3);
            c[15:14] = 2'(t);
            if (t == 0 && $urandom_range(0, 2) == 0) c[13:8] = 6'd0;
            nb = $urandom_range(0, 9);
            nb = (nb == 0) ? $urandom_range(4, 15) : (nb == 1) ? $urandom_range(17, 20) : 16;
            frame(c, nb, -1);
        end
        frame(16'h6A00, 16, -1);
        frame(16'h6A00, 16, -1);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rhd_spi_slave_bank.md
# rhd_spi_slave_bank

Parametrised, cycle-accurate emulator of a bank of RHD-style SPI amplifier slaves for simulation and FPGA loop-back self-test of the multi-port recording master. It oversamples SCLK, CS and MOSI on the system clock and decodes 16-bit commands. It drives `NUM_LANES` MISO lines with deterministic per-lane data, using the chip's two-frame response pipeline. It replaces per-lane hand-instantiated slave models: it decodes the channel from MOSI itself, supports WRITE/READ commands, and handles aborted frames.

## Interface
- `NUM_LANES`, 32: number of emulated MISO lines, 1..64.
- `NUM_CHANNELS`, 64: CONVERT channel indices `>= NUM_CHANNELS` return 16'h0000.
- `STARTING_SEED`, 0: data offset of lane 0.
- `SEED_STRIDE`, 64: data offset added per lane index.
- `clk` in 1: system clock; SCLK is at most clk/4.
- `rst` in 1: synchronous, active-high reset.
- `SCLK` in 1: SPI clock from the master, idle low, asynchronous to `clk`.
- `CS` in 1: active-low frame select, asynchronous.
- `MOSI` in 1: command data, MSB first, asynchronous.
- `MISO` out `NUM_LANES`: response data per lane, MSB first.
- `frame_done` out 1: one-cycle pulse when a complete 16-bit frame ends.
- `cmd_last` out 16: last complete command received.
- `sample_count` out 16: CONVERT(0) counter.

## Operation
- SCLK, CS and MOSI each pass through a 2-FF synchroniser, then a registered edge detector.
- Frame start: CS falling edge.
  - Bit counter cleared.
  - Shift-out register of each lane loaded from pipeline stage `resp2[lane]`.
  - MISO drives the MSB.
- SCLK rising edge inside a frame:
  - MOSI is shifted into `cmd_sr`.
  - Bit counter increments, saturating at 16.
- SCLK falling edge inside a frame: each lane shifts its register left and drives the next bit. After bit 16, MISO drives 0.
- Frame end (CS rising edge) with bit counter == 16: the command is complete.
  - `cmd_last <= cmd_sr`.
  - `frame_done` pulses.
  - Pipeline advances: `resp2 <= resp1`, `resp1 <= f(cmd)`.
- Frame end with bit counter != 16: aborted frame.
  - No pipeline advance, no `frame_done`, `cmd_last` unchanged.
- Response function f per lane L:
  - CONVERT `00CCCCCC_xxxxxxxx`: `(STARTING_SEED + L*SEED_STRIDE + C + sample_count) mod 2^16` for C < `NUM_CHANNELS`; otherwise 16'h0000.
  - After the response is computed, `sample_count` increments when C == 0 (wraps 16'hFFFF→0).
  - WRITE `10RRRRRR_DDDDDDDD`: response {8'hFF, D}.
  - READ `11RRRRRR_xxxxxxxx`: response {8'h00, reg[R]} (see Configuration).
  - Any other command (CALIBRATE, CLEAR, `01xxxxxx`): response 16'h0000.
- Every lane decodes the same command. Lanes differ only by their seed.

## Timing
- Reset values:
  - MISO all 0, `frame_done` 0, `cmd_last` 16'h0000, `sample_count` 0.
  - Both pipeline stages 16'h0000; bit counter 0; frame-active flag 0.
  - Register file (if present) all 0.
- Latency from asynchronous pin to internal edge: 3 `clk` cycles (2 sync + 1 edge register). Valid MISO bit is driven no later than 4 `clk` after the SCLK falling edge or CS falling edge.
- `frame_done` asserts exactly 4 `clk` after the CS rising pin edge.
- Response latency: the response to command N appears in frame N+2. The first two frames after reset return 16'h0000.
- SCLK edges while CS is high are ignored.
- CS falling and SCLK edges synchronised in the same cycle: the frame start is processed first, and the SCLK edge is ignored.
- `rst` mid-frame: all state returns to reset values immediately. The remainder of the frame is treated as CS high until the next CS falling edge.
- More than 16 SCLK pulses in a frame: extra MOSI bits are ignored, MISO drives 0, and the frame counts as complete.

## Configuration
- `RHD_SLAVE_REGFILE_EN` defined:
  - A 64×8 register file per bank (shared by all lanes).
  - WRITE stores D at R. READ returns the stored byte.
  - Registers 40–44 are read-only and return ASCII "INTAN" (8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E); writes to them are ignored.
- `RHD_SLAVE_REGFILE_EN` undefined: no storage. READ returns 16'h0000 for every R, including 40–44. WRITE response is unchanged.

## Test plan
- Reset, then a CONVERT(5) frame on lane 1 (seed 0, stride 64): frames 1–2 return 16'h0000. The third frame (e.g. CONVERT(0)) returns 16'h0045 on MISO[1] and 16'h0005 on MISO[0].
- Three CONVERT(0) frames: `sample_count` goes 0→1→2→3. The response to the second CONVERT(0) on lane 0 is 16'h0001.
- WRITE 16'h8A3C, then two dummy frames: response 16'hFF3C. With the macro, a following READ(10) returns 16'h003C two frames later. Without the macro it returns 16'h0000.
- READ(40..44) with the macro: responses 16'h0049, 004E, 0054, 0041, 004E. Writes to 41 leave it at 8'h4E.
- Aborted frame (CS high after 9 SCLKs), then a full frame: no `frame_done` for the abort, pipeline not advanced, `cmd_last` holds the prior value.
- `rst` asserted for 1 cycle at bit 7 of a frame: MISO = 0, `cmd_last` = 0. The next full frame's `frame_done` occurs 4 `clk` after CS rises, and its response is 16'h0000.
